// File: rtl/fft_frame_reader.sv
// Frame reader: once the FIFO holds a full frame, pulls FRAME_LEN samples and
// streams them through a 2-entry skid buffer with valid/ready handshaking.
module fft_frame_reader #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WIDTH = 10,
   parameter int FRAME_LEN   = 256
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   input  logic [DEPTH_WIDTH:0]  fifo_rd_water_level,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt
);
   localparam logic [DEPTH_WIDTH:0] FRAME_LEN_W = (DEPTH_WIDTH+1)'(FRAME_LEN);
   localparam logic [DEPTH_WIDTH:0] LAST_IDX    = (DEPTH_WIDTH+1)'(FRAME_LEN - 1);
   localparam logic [DEPTH_WIDTH:0] CNT_ONE     = (DEPTH_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READ  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] skid0;
   logic [DATA_WIDTH-1:0] skid1;
   logic [1:0]            skid_cnt;
   logic                  in_flight;
   logic [DEPTH_WIDTH:0]  rd_cnt;
   logic [DEPTH_WIDTH:0]  beat_cnt;
   logic                  pop;
   logic                  push;
   logic                  last_beat;
   logic [2:0]            occupancy;

   assign pop       = m_valid & m_ready;
   assign push      = in_flight;
   assign last_beat = pop & (beat_cnt == LAST_IDX);

   // Slot being drained this cycle counts as free, so a steady stream with
   // m_ready high sustains one read per cycle without ever exceeding 2 entries.
   assign occupancy  = {1'b0, skid_cnt} - {2'b00, pop} + {2'b00, in_flight};
   assign fifo_rd_en = (state == READ) & ~fifo_rd_empty & (occupancy < 3'd2);

   assign m_valid = (skid_cnt != 2'd0);
   assign m_data  = skid0;
   assign m_last  = m_valid & (beat_cnt == LAST_IDX);
   assign busy    = (state == READ) | (state == FLUSH);

   // Frame FSM, skid buffer, read/beat counters and completion bookkeeping
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state      <= IDLE;
         skid0      <= '0;
         skid1      <= '0;
         skid_cnt   <= 2'd0;
         in_flight  <= 1'b0;
         rd_cnt     <= '0;
         beat_cnt   <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= 16'd0;
      end else begin
         in_flight  <= fifo_rd_en;
         frame_done <= 1'b0;

         case ({push, pop})
            2'b10: begin
               if (skid_cnt == 2'd0) skid0 <= fifo_rd_data;
               else                  skid1 <= fifo_rd_data;
               skid_cnt <= skid_cnt + 2'd1;
            end
            2'b01: begin
               skid0    <= skid1;
               skid_cnt <= skid_cnt - 2'd1;
            end
            2'b11: begin
               if (skid_cnt == 2'd1) begin
                  skid0 <= fifo_rd_data;
               end else begin
                  skid0 <= skid1;
                  skid1 <= fifo_rd_data;
               end
            end
            default: ;
         endcase

         if (pop)        beat_cnt <= beat_cnt + CNT_ONE;
         if (fifo_rd_en) rd_cnt   <= rd_cnt + CNT_ONE;

         case (state)
            IDLE: begin
               if (enable) state <= WAIT;
            end
            WAIT: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (fifo_rd_water_level >= FRAME_LEN_W) begin
                  state    <= READ;
                  rd_cnt   <= '0;
                  beat_cnt <= '0;
               end
            end
            READ: begin
               if (fifo_rd_en && (rd_cnt == LAST_IDX)) state <= FLUSH;
            end
            FLUSH: begin
               if (last_beat) begin
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 16'd1;
                  state      <= enable ? WAIT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fft_frame_reader.md
FFT_FRAME_READER -- requirements
Module: fft_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning sample width of FIFO read data and output stream.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 10, meaning FIFO depth width; the water-level input is DEPTH_WIDTH+1 bits.
REQ-003 SHALL have parameter FRAME_LEN, default 256, meaning samples per frame; legal range 2..2^DEPTH_WIDTH.
REQ-004 SHALL use one clock and a synchronous, active-high reset: rd_clk input 1 (clock, all logic on rising edge), then rd_rst input 1 (synchronous, active-high reset).
REQ-005 SHALL have enable, input, 1 bit: permits frame starts.
REQ-006 SHALL have fifo_rd_en, output, 1 bit: read strobe to the upstream FIFO.
REQ-007 SHALL have fifo_rd_data, input, DATA_WIDTH bits: FIFO read data, valid exactly 1 cycle after fifo_rd_en.
REQ-008 SHALL have fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-009 SHALL have fifo_rd_water_level, input, DEPTH_WIDTH+1 bits: current FIFO occupancy.
REQ-010 SHALL have m_data, output, DATA_WIDTH bits: output sample.
REQ-011 SHALL have m_valid, output, 1 bit: m_data valid.
REQ-012 SHALL have m_ready, input, 1 bit: downstream accept; a beat transfers when m_valid and m_ready are both high.
REQ-013 SHALL have m_last, output, 1 bit: marks the final beat of a frame.
REQ-014 SHALL have busy, output, 1 bit: high in any state other than IDLE or WAIT.
REQ-015 SHALL have frame_done, output, 1 bit: one-cycle pulse when the last beat transfers.
REQ-016 SHALL have frame_cnt, output, 16 bits: count of completed frames; wraps at 65535 to 0.

Function
REQ-017 SHALL implement the states IDLE, WAIT, READ and FLUSH.
REQ-018 IDLE -> WAIT when enable=1; WAIT -> IDLE when enable=0.
REQ-019 WAIT -> READ when fifo_rd_water_level >= FRAME_LEN, so a frame never starts partially filled.
REQ-020 In READ, fifo_rd_en SHALL be high only when fifo_rd_empty=0 and (skid occupancy + reads in flight) < 2.
REQ-021 READ -> FLUSH in the cycle the FRAME_LEN-th read is issued; fifo_rd_en SHALL stay low in FLUSH, WAIT and IDLE.
REQ-022 Returned data SHALL enter a 2-entry skid buffer the cycle after fifo_rd_en; the buffer SHALL never overflow, and no sample is dropped or duplicated under any m_ready pattern.
REQ-023 m_valid SHALL be high whenever the skid buffer is non-empty; m_data is the oldest entry; m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-024 Output order SHALL equal FIFO read order.
REQ-025 m_last SHALL be high exactly on beat FRAME_LEN of each frame, counted by an output-beat counter cleared at frame start.
REQ-026 On the last-beat transfer: frame_done=1 for one cycle and frame_cnt increments; the FSM goes FLUSH -> WAIT if enable=1, else FLUSH -> IDLE.
REQ-027 Deasserting enable during READ or FLUSH SHALL NOT abort the frame; the frame completes in full.
REQ-028 With m_ready held high and the FIFO non-empty, throughput SHALL be 1 beat per cycle after a 2-cycle start latency: WAIT->READ, then first fifo_rd_en, then m_valid.
REQ-029 fifo_rd_empty rising mid-frame SHALL stall issue only; the frame resumes when empty deasserts.
REQ-030 The next frame's WAIT->READ evaluation SHALL start in the cycle after frame_done.

Reset
REQ-031 With rd_rst=1 at a clock edge, next state SHALL be IDLE, and fifo_rd_en, m_valid, m_last, busy and frame_done SHALL all be 0.
REQ-032 rd_rst SHALL set m_data, frame_cnt, the skid buffer, the in-flight flag and both counters to 0.
REQ-033 A reset asserted mid-frame SHALL discard all buffered and in-flight data; the FIFO is not re-read to recover it.

Verification
REQ-034 Scenario: FRAME_LEN=8, FIFO preloaded with 0..9, enable=1, m_ready=1 -> exactly 8 beats with data 0..7; m_last on data 7; frame_done pulses once; frame_cnt=1; FSM returns to WAIT with level 2.
REQ-035 Scenario: level=7 with FRAME_LEN=8 -> no fifo_rd_en; after one more write, the frame starts within 2 cycles.
REQ-036 Scenario: random m_ready at 30% duty over 4 frames -> 32 beats in order, no gaps or duplicates, m_data stable while stalled, frame_cnt=4.
REQ-037 Scenario: enable dropped at beat 3 -> all 8 beats delivered, then IDLE with busy=0.
REQ-038 Scenario: rd_rst pulsed at beat 5 with m_ready=0 -> next cycle m_valid=0, frame_cnt=0, IDLE; no further fifo_rd_en until enable is asserted and level >= 8.
REQ-039 Scenario: fifo_rd_empty forced high for 5 cycles mid-frame -> fifo_rd_en stays low during those cycles and the frame completes with correct data and a single m_last.
